// File: rtl/riio_gpo_bank_ctrl.sv
// Configuration sequencer and VBIAS gating for a bank of EG1D80V output pads.
// Each channel reconfigures in a break-before-make sequence: BREAK, then LOAD, then MAKE.

module riio_gpo_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       brk,
  input  logic       ld,
  input  logic       mk,
  input  logic       bias_rdy,
  input  logic       data,
  input  logic [1:0] new_mode,
  input  logic [1:0] new_ds,
  input  logic       new_sr,
  output logic       dout,
  output logic [1:0] ds,
  output logic       sr,
  output logic       oe,
  output logic       odp,
  output logic       odn,
  output logic       act
);
  logic [1:0] mode_q;
  logic [1:0] ds_q;
  logic       sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout   <= 1'b0;
      oe     <= 1'b0;
      mode_q <= 2'b00;
      ds_q   <= 2'b00;
      sr_q   <= 1'b0;
    end else begin
      dout <= data;
      if (sel && brk) oe <= 1'b0;
      if (sel && ld) begin
        mode_q <= new_mode;
        ds_q   <= new_ds;
        sr_q   <= new_sr;
      end
      // OE comes back only after the new mode/ds/sr have reached the pad.
      if (sel && mk) oe <= (mode_q != 2'b00);
    end
  end

  assign odp = (mode_q == 2'b11);
  assign odn = (mode_q == 2'b10);
  assign sr  = sr_q;
  assign ds  = bias_rdy ? ds_q : 2'b00;
  assign act = (mode_q != 2'b00) && (ds_q != 2'b00);
endmodule

module riio_gpo_bank_ctrl #(
  parameter int NCH        = 8,
  parameter int SETTLE_CYC = 64,
  parameter int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             CFG_VALID_I,
  output logic             CFG_READY_O,
  input  logic [CHW-1:0]   CFG_CH_I,
  input  logic [1:0]       CFG_MODE_I,
  input  logic [1:0]       CFG_DS_I,
  input  logic             CFG_SR_I,
  input  logic [NCH-1:0]   DATA_I,
  output logic [NCH-1:0]   DO_O,
  output logic [2*NCH-1:0] DS_O,
  output logic [NCH-1:0]   SR_O,
  output logic [NCH-1:0]   OE_O,
  output logic [NCH-1:0]   ODP_O,
  output logic [NCH-1:0]   ODN_O,
  output logic             BIAS_EN_O,
  output logic             BIAS_RDY_O
);
  localparam int             CW    = $clog2(SETTLE_CYC);
  localparam logic [CHW:0]   NCH_W = (CHW+1)'(NCH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {C_IDLE, C_BREAK, C_LOAD, C_MAKE} cfg_st_t;
  typedef enum logic [1:0] {B_OFF, B_SETTLE, B_ON} bias_st_t;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           hit;
    logic [1:0]     mode;
    logic [1:0]     ds;
    logic           sr;
  } cfg_req_t;

  cfg_st_t        cst;
  cfg_req_t       req;
  bias_st_t       bst;
  logic [CW-1:0]  cnt;
  logic [NCH-1:0] act;
  logic           need_bias;

  assign CFG_READY_O = (cst == C_IDLE) && !RST_I;

  // Out-of-range requests still walk the full sequence; hit=0 keeps every lane untouched.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cst <= C_IDLE;
      req <= '0;
    end else begin
      case (cst)
        C_IDLE: if (CFG_VALID_I) begin
          req.ch   <= CFG_CH_I;
          req.hit  <= ({1'b0, CFG_CH_I} < NCH_W);
          req.mode <= CFG_MODE_I;
          req.ds   <= CFG_DS_I;
          req.sr   <= CFG_SR_I;
          cst      <= C_BREAK;
        end
        C_BREAK: cst <= C_LOAD;
        C_LOAD:  cst <= C_MAKE;
        default: cst <= C_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    riio_gpo_lane u_lane (
      .clk      (CLK_I),
      .rst      (RST_I),
      .sel      (req.hit && (req.ch == CHW'(i))),
      .brk      (cst == C_BREAK),
      .ld       (cst == C_LOAD),
      .mk       (cst == C_MAKE),
      .bias_rdy (BIAS_RDY_O),
      .data     (DATA_I[i]),
      .new_mode (req.mode),
      .new_ds   (req.ds),
      .new_sr   (req.sr),
      .dout     (DO_O[i]),
      .ds       (DS_O[2*i +: 2]),
      .sr       (SR_O[i]),
      .oe       (OE_O[i]),
      .odp      (ODP_O[i]),
      .odn      (ODN_O[i]),
      .act      (act[i])
    );
  end

  assign need_bias = |act;

  // Any loss of demand restarts the settle from zero; there is no warm restart.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      bst        <= B_OFF;
      cnt        <= '0;
      BIAS_EN_O  <= 1'b0;
      BIAS_RDY_O <= 1'b0;
    end else begin
      case (bst)
        B_OFF: begin
          cnt <= '0;
          if (need_bias) begin
            bst       <= B_SETTLE;
            BIAS_EN_O <= 1'b1;
          end
        end
        B_SETTLE: begin
          if (!need_bias) begin
            bst       <= B_OFF;
            cnt       <= '0;
            BIAS_EN_O <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            bst        <= B_ON;
            BIAS_RDY_O <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (!need_bias) begin
            bst        <= B_OFF;
            BIAS_EN_O  <= 1'b0;
            BIAS_RDY_O <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_riio_gpo_bank_ctrl.sv
// Scenario tasks plus a randomized run, all checked against a cycle-level behavioural model.
module tb_riio_gpo_bank_ctrl;
  localparam int NCH = 6;
  localparam int SC  = 64;
  localparam int CHW = $clog2(NCH);

  logic             CLK_I = 1'b0;
  logic             RST_I = 1'b1;
  logic             CFG_VALID_I = 1'b0;
  logic             CFG_READY_O;
  logic [CHW-1:0]   CFG_CH_I = '0;
  logic [1:0]       CFG_MODE_I = '0;
  logic [1:0]       CFG_DS_I = '0;
  logic             CFG_SR_I = 1'b0;
  logic [NCH-1:0]   DATA_I = '0;
  logic [NCH-1:0]   DO_O, SR_O, OE_O, ODP_O, ODN_O;
  logic [2*NCH-1:0] DS_O;
  logic             BIAS_EN_O, BIAS_RDY_O;

  riio_gpo_bank_ctrl #(.NCH(NCH), .SETTLE_CYC(SC)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CFG_VALID_I(CFG_VALID_I), .CFG_READY_O(CFG_READY_O),
    .CFG_CH_I(CFG_CH_I), .CFG_MODE_I(CFG_MODE_I), .CFG_DS_I(CFG_DS_I), .CFG_SR_I(CFG_SR_I),
    .DATA_I(DATA_I), .DO_O(DO_O), .DS_O(DS_O), .SR_O(SR_O), .OE_O(OE_O),
    .ODP_O(ODP_O), .ODN_O(ODN_O), .BIAS_EN_O(BIAS_EN_O), .BIAS_RDY_O(BIAS_RDY_O)
  );

  always #5 CLK_I = ~CLK_I;

  int vectors = 0;
  int miscompares = 0;

  // Model: stored config per channel, OE per channel, edges since accept, and the
  // length of the current unbroken run of edges at which bias was needed.
  int             m_mode[NCH], m_ds[NCH], m_sr[NCH];
  bit             m_oe[NCH];
  logic [NCH-1:0] m_do = '0;
  int             run = 0, age = 0;
  int             r_ch, r_mode, r_ds, r_sr;
  bit             accepted = 0;
  logic [NCH-1:0]   e_do, e_sr, e_oe, e_odp, e_odn;
  logic [2*NCH-1:0] e_ds;
  logic             e_en, e_rdy;

  task automatic tick();
    bit need;
    @(posedge CLK_I);
    accepted = 0;
    if (RST_I) begin
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0; m_ds[i] = 0; m_sr[i] = 0; m_oe[i] = 0;
      end
      m_do = '0; run = 0; age = 0;
    end else begin
      need = 0;
      for (int i = 0; i < NCH; i++) if (m_mode[i] != 0 && m_ds[i] != 0) need = 1;
      run  = need ? run + 1 : 0;
      m_do = DATA_I;
      case (age)
        0: if (CFG_VALID_I) begin
          r_ch = int'(CFG_CH_I); r_mode = int'(CFG_MODE_I); r_ds = int'(CFG_DS_I); r_sr = int'(CFG_SR_I);
          age = 1; accepted = 1;
        end
        1: begin if (r_ch < NCH) m_oe[r_ch] = 0; age = 2; end
        2: begin
          if (r_ch < NCH) begin m_mode[r_ch] = r_mode; m_ds[r_ch] = r_ds; m_sr[r_ch] = r_sr; end
          age = 3;
        end
        default: begin if (r_ch < NCH) m_oe[r_ch] = (m_mode[r_ch] != 0); age = 0; end
      endcase
    end
    e_en  = (run >= 1);
    e_rdy = (run >= SC + 1);
    e_do  = m_do;
    for (int i = 0; i < NCH; i++) begin
      e_ds[2*i +: 2] = e_rdy ? 2'(m_ds[i]) : 2'b00;
      e_sr[i]  = (m_sr[i] != 0);
      e_oe[i]  = m_oe[i];
      e_odp[i] = (m_mode[i] == 3);
      e_odn[i] = (m_mode[i] == 2);
    end
    #1;
  endtask

  task automatic send(input int ch, input int mode, input int ds, input int sr);
    bit done = 0;
    CFG_VALID_I = 1'b1;
    CFG_CH_I = CHW'(ch); CFG_MODE_I = 2'(mode); CFG_DS_I = 2'(ds); CFG_SR_I = sr[0];
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      done = accepted;
    end
    CFG_VALID_I = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout ch=%0d never accepted", ch);
    end
  endtask

  task automatic test_reset();
    RST_I = 1'b1;
    tick(); tick();
    vectors++;
    if ({DO_O, DS_O, SR_O, OE_O, ODP_O, ODN_O, BIAS_EN_O, BIAS_RDY_O} !== '0) begin
      miscompares++;
      $display("FAIL rst_outputs got do=%h ds=%h sr=%h oe=%h odp=%h odn=%h en=%b rdy=%b exp all 0",
               DO_O, DS_O, SR_O, OE_O, ODP_O, ODN_O, BIAS_EN_O, BIAS_RDY_O);
    end
    vectors++;
    if (CFG_READY_O !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b exp 0", CFG_READY_O); end
    RST_I = 1'b0;
    #1;
    vectors++;
    if (CFG_READY_O !== 1'b1) begin miscompares++; $display("FAIL ready_after_rst got %b exp 1", CFG_READY_O); end
  endtask

  task automatic test_data();
    DATA_I = 6'b100101;
    tick();
    vectors++;
    if (DO_O !== 6'b100101) begin miscompares++; $display("FAIL data_latency got %h exp 25", DO_O); end
    DATA_I = 6'b011010;
    tick();
    vectors++;
    if (DO_O !== e_do) begin miscompares++; $display("FAIL data_model got %h exp %h", DO_O, e_do); end
  endtask

  task automatic test_pushpull();
    send(2, 1, 0, 0);
    vectors++;
    if (CFG_READY_O !== 1'b0) begin miscompares++; $display("FAIL pp_ready_low got %b exp 0", CFG_READY_O); end
    tick();
    vectors++;
    if (OE_O[2] !== 1'b0) begin miscompares++; $display("FAIL pp_oe_break got %b exp 0", OE_O[2]); end
    tick();
    vectors++;
    if (OE_O[2] !== 1'b0 || CFG_READY_O !== 1'b0) begin
      miscompares++; $display("FAIL pp_load got oe=%b rdy=%b exp oe=0 rdy=0", OE_O[2], CFG_READY_O);
    end
    tick();
    vectors++;
    if (OE_O[2] !== 1'b1 || ODP_O[2] !== 1'b0 || ODN_O[2] !== 1'b0 || CFG_READY_O !== 1'b1) begin
      miscompares++;
      $display("FAIL pp_make got oe=%b odp=%b odn=%b rdy=%b exp 1 0 0 1", OE_O[2], ODP_O[2], ODN_O[2], CFG_READY_O);
    end
    vectors++;
    if (BIAS_EN_O !== 1'b0 || OE_O !== e_oe) begin
      miscompares++; $display("FAIL pp_bias_oe got en=%b oe=%h exp en=0 oe=%h", BIAS_EN_O, OE_O, e_oe);
    end
  endtask

  task automatic test_bias_settle();
    int en_at = -1, rdy_at = -1;
    send(5, 2, 3, 0);
    for (int k = 0; k < 200 && rdy_at < 0; k++) begin
      tick();
      if (en_at < 0 && BIAS_EN_O === 1'b1) en_at = k;
      if (BIAS_RDY_O === 1'b1) rdy_at = k;
      if (k == 2) begin
        vectors++;
        if (OE_O[5] !== 1'b1 || ODN_O[5] !== 1'b1 || DS_O[11:10] !== 2'b00) begin
          miscompares++;
          $display("FAIL od_make got oe=%b odn=%b ds=%b exp 1 1 00", OE_O[5], ODN_O[5], DS_O[11:10]);
        end
      end
      vectors++;
      if (DS_O !== e_ds || BIAS_EN_O !== e_en || BIAS_RDY_O !== e_rdy) begin
        miscompares++;
        $display("FAIL settle_k%0d got ds=%h en=%b rdy=%b exp ds=%h en=%b rdy=%b",
                 k, DS_O, BIAS_EN_O, BIAS_RDY_O, e_ds, e_en, e_rdy);
      end
    end
    vectors++;
    if (en_at != 2 || rdy_at - en_at != SC) begin
      miscompares++; $display("FAIL settle_time got en_at=%0d rdy_at=%0d exp 2 %0d", en_at, rdy_at, 2 + SC);
    end
    vectors++;
    if (DS_O[11:10] !== 2'b11) begin miscompares++; $display("FAIL ds_release got %b exp 11", DS_O[11:10]); end
  endtask

  task automatic test_release();
    send(5, 0, 3, 0);
    tick();
    vectors++;
    if (OE_O[5] !== 1'b0 || BIAS_EN_O !== 1'b1) begin
      miscompares++; $display("FAIL rel_break got oe=%b en=%b exp 0 1", OE_O[5], BIAS_EN_O);
    end
    tick();
    vectors++;
    if (BIAS_EN_O !== 1'b1 || BIAS_RDY_O !== 1'b1) begin
      miscompares++; $display("FAIL rel_load got en=%b rdy=%b exp 1 1", BIAS_EN_O, BIAS_RDY_O);
    end
    tick();
    vectors++;
    if (BIAS_EN_O !== 1'b0 || BIAS_RDY_O !== 1'b0 || OE_O[5] !== 1'b0) begin
      miscompares++; $display("FAIL rel_off got en=%b rdy=%b oe=%b exp 0 0 0", BIAS_EN_O, BIAS_RDY_O, OE_O[5]);
    end
  endtask

  task automatic test_settle_abort();
    int en_at = -1, rdy_at = -1;
    send(1, 1, 1, 0);
    for (int k = 0; k < 10 && BIAS_EN_O !== 1'b1; k++) tick();
    // EN edge leaves the count at 0; accept on the 8th edge after puts LOAD at count 10.
    repeat (7) tick();
    send(1, 0, 1, 0);
    tick(); tick();
    vectors++;
    if (BIAS_EN_O !== 1'b1 || BIAS_RDY_O !== 1'b0) begin
      miscompares++; $display("FAIL abort_load got en=%b rdy=%b exp 1 0", BIAS_EN_O, BIAS_RDY_O);
    end
    tick();
    vectors++;
    if (BIAS_EN_O !== 1'b0 || BIAS_EN_O !== e_en) begin
      miscompares++; $display("FAIL abort_off got en=%b exp 0", BIAS_EN_O);
    end
    send(1, 1, 1, 0);
    for (int k = 0; k < 200 && rdy_at < 0; k++) begin
      tick();
      if (en_at < 0 && BIAS_EN_O === 1'b1) en_at = k;
      if (BIAS_RDY_O === 1'b1) rdy_at = k;
      vectors++;
      if (BIAS_EN_O !== e_en || BIAS_RDY_O !== e_rdy || DS_O !== e_ds) begin
        miscompares++;
        $display("FAIL resettle_k%0d got en=%b rdy=%b ds=%h exp %b %b %h",
                 k, BIAS_EN_O, BIAS_RDY_O, DS_O, e_en, e_rdy, e_ds);
      end
    end
    vectors++;
    if (en_at < 0 || rdy_at - en_at != SC) begin
      miscompares++; $display("FAIL resettle_time got en_at=%0d rdy_at=%0d exp gap %0d", en_at, rdy_at, SC);
    end
  endtask

  task automatic test_out_of_range();
    send(NCH, 1, 3, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (OE_O !== e_oe || ODP_O !== e_odp || ODN_O !== e_odn || SR_O !== e_sr || DS_O !== e_ds) begin
        miscompares++;
        $display("FAIL oor_k%0d got oe=%h odp=%h odn=%h sr=%h ds=%h exp %h %h %h %h %h",
                 k, OE_O, ODP_O, ODN_O, SR_O, DS_O, e_oe, e_odp, e_odn, e_sr, e_ds);
      end
    end
    vectors++;
    if (CFG_READY_O !== 1'b1) begin miscompares++; $display("FAIL oor_ready got %b exp 1", CFG_READY_O); end
  endtask

  task automatic test_reset_mid();
    send(3, 1, 2, 1);
    RST_I = 1'b1;
    tick();
    vectors++;
    if ({DO_O, DS_O, SR_O, OE_O, ODP_O, ODN_O, BIAS_EN_O, BIAS_RDY_O, CFG_READY_O} !== '0) begin
      miscompares++;
      $display("FAIL midrst_outs got oe=%h odp=%h sr=%h ds=%h en=%b rdy=%b ready=%b exp all 0",
               OE_O, ODP_O, SR_O, DS_O, BIAS_EN_O, BIAS_RDY_O, CFG_READY_O);
    end
    RST_I = 1'b0;
    repeat (4) tick();
    vectors++;
    if (OE_O[3] !== 1'b0 || ODP_O[3] !== 1'b0 || ODN_O[3] !== 1'b0 || SR_O[3] !== 1'b0 ||
        BIAS_EN_O !== 1'b0 || CFG_READY_O !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_cfg got oe=%b odp=%b odn=%b sr=%b en=%b ready=%b exp 0 0 0 0 0 1",
               OE_O[3], ODP_O[3], ODN_O[3], SR_O[3], BIAS_EN_O, CFG_READY_O);
    end
  endtask

  task automatic test_random();
    logic [NCH*6+5:0] got, exp;
    for (int k = 0; k < 1500; k++) begin
      DATA_I = NCH'($urandom);
      RST_I  = ($urandom_range(0, 299) == 0);
      if (!CFG_VALID_I && $urandom_range(0, 3) == 0) begin
        CFG_VALID_I = 1'b1;
        CFG_CH_I    = CHW'($urandom_range(0, (1 << CHW) - 1));
        CFG_MODE_I  = 2'($urandom);
        CFG_DS_I    = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
        CFG_SR_I    = 1'($urandom);
      end
      tick();
      if (accepted) CFG_VALID_I = 1'b0;
      got = {DO_O, DS_O, SR_O, OE_O, ODP_O, ODN_O, BIAS_EN_O, BIAS_RDY_O};
      exp = {e_do, e_ds, e_sr, e_oe, e_odp, e_odn, e_en, e_rdy};
      vectors++;
      if (got !== exp || CFG_READY_O !== ((age == 0) && !RST_I)) begin
        miscompares++;
        $display("FAIL rand_k%0d got %h ready=%b exp %h ready=%b", k, got, CFG_READY_O, exp, (age == 0) && !RST_I);
      end
    end
    CFG_VALID_I = 1'b0;
    RST_I = 1'b0;
  endtask

  initial begin
    test_reset();
    test_data();
    test_pushpull();
    test_bias_settle();
    test_release();
    test_settle_abort();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
